// File: rtl/ce_synth_if.sv
// ce_synth_if
// Configuration bus for the clock-enable synthesiser.
//   cfg_we     : write strobe for one channel increment
//   cfg_ch     : target channel index
//   cfg_inc    : new phase increment
//   phase_sync : clears every channel accumulator on the same edge
// The master modport drives the bus; ce_synth takes the slave modport.
interface ce_synth_if #(
  parameter int CH_W  = 2,
  parameter int ACC_W = 32
);
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic             phase_sync;

  modport master (output cfg_we, cfg_ch, cfg_inc, phase_sync);
  modport slave  (input  cfg_we, cfg_ch, cfg_inc, phase_sync);
endinterface

// File: rtl/ce_synth.sv
// ce_synth
// Multi-channel fractional clock-enable synthesiser. Each channel owns a
// phase accumulator; every wrap produces a one-cycle enable, and the
// accumulator MSB gives a ~50% duty square wave. A per-channel lock FSM
// reports when a freshly programmed rate has had SETTLE cycles to settle.
// Ports:
//   refclk    : sole clock, rising edge
//   rst_n     : asynchronous active-low reset
//   cfg       : configuration bus (slave side of ce_synth_if)
//   ce        : per-channel enable pulse, one cycle per accumulator wrap
//   outclk    : per-channel accumulator MSB, registered
//   ch_locked : per-channel "running and settled"
//   locked    : AND of all ch_locked, aligned with ch_locked
module ce_synth #(
  parameter int                        CHANNELS = 3,
  parameter int                        ACC_W    = 32,
  parameter int                        SETTLE   = 16,
  parameter logic [CHANNELS*ACC_W-1:0] INIT_INC = '0
) (
  input  logic                refclk,
  input  logic                rst_n,
  ce_synth_if.slave           cfg,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] outclk,
  output logic [CHANNELS-1:0] ch_locked,
  output logic                locked
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // Counter only needs to hold SETTLE-1.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLING,
    ST_LOCKED
  } lock_state_e;

  // Out-of-range channel numbers are dropped here so no channel sees them.
  logic                cfg_hit;
  logic [CHANNELS-1:0] lock_next;
  logic                locked_reg;

  assign cfg_hit = cfg.cfg_we && (32'(cfg.cfg_ch) < CHANNELS);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    localparam logic [ACC_W-1:0] INC_RST = INIT_INC[gi*ACC_W +: ACC_W];

    logic [ACC_W-1:0] inc_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W:0]   sum;
    logic             ce_reg;
    logic             outclk_reg;
    logic             lck_reg;
    logic             wr_hit;
    lock_state_e      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    assign wr_hit = cfg_hit && (cfg.cfg_ch == CH_W'(gi));
    // Carry out of the add is the wrap event.
    assign sum    = {1'b0, acc_reg} + {1'b0, inc_reg};

    // Datapath: the add on a write edge still uses the old increment, so a
    // rate change is phase-continuous and the new rate starts one edge later.
    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        inc_reg    <= INC_RST;
        acc_reg    <= '0;
        ce_reg     <= 1'b0;
        outclk_reg <= 1'b0;
      end else begin
        if (wr_hit) begin
          inc_reg <= cfg.cfg_inc;
        end
        if (cfg.phase_sync) begin
          acc_reg    <= '0;
          ce_reg     <= 1'b0;
          outclk_reg <= 1'b0;
        end else begin
          acc_reg    <= sum[ACC_W-1:0];
          ce_reg     <= sum[ACC_W];
          outclk_reg <= sum[ACC_W-1];
        end
      end
    end

    // Lock FSM state register.
    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg <= (INC_RST != '0) ? ST_SETTLING : ST_IDLE;
        cnt_reg   <= (INC_RST != '0) ? CNT_LOAD : '0;
        lck_reg   <= 1'b0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        lck_reg   <= lock_next[gi];
      end
    end

    // Lock FSM next state: any accepted write restarts from scratch.
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (wr_hit) begin
        if (cfg.cfg_inc == '0) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          state_next = ST_SETTLING;
          cnt_next   = CNT_LOAD;
        end
      end else begin
        case (state_reg)
          ST_SETTLING: begin
            if (cnt_reg == '0) begin
              state_next = ST_LOCKED;
            end else begin
              cnt_next = cnt_reg - CNT_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end

    assign lock_next[gi] = (state_next == ST_LOCKED);
    assign ce[gi]        = ce_reg;
    assign outclk[gi]    = outclk_reg;
    assign ch_locked[gi] = lck_reg;
  end

  // Built from next-state bits so it lands on the same edge as ch_locked.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      locked_reg <= 1'b0;
    end else begin
      locked_reg <= &lock_next;
    end
  end

  assign locked = locked_reg;

endmodule

// File: tb/tb_ce_synth.sv
// tb_ce_synth
// Directed bench for ce_synth (CHANNELS=3, ACC_W=8, SETTLE=16,
// INIT_INC = {ch2=0x00, ch1=0x10, ch0=0x80}). Expected output samples are
// queued with the cycle they belong to; a monitor process samples the
// outputs every cycle and compares against due entries. "cycle n" means the
// value visible after the n-th rising edge of refclk.
module tb_ce_synth;

  localparam int CHANNELS = 3;
  localparam int ACC_W    = 8;
  localparam int SETTLE   = 16;
  localparam int CH_W     = 2;

  localparam int K_CE     = 0;
  localparam int K_OCLK   = 1;
  localparam int K_LCK    = 2;
  localparam int K_LOCKED = 3;
  localparam int K_CNT    = 4;
  localparam int K_CLR    = 5;

  logic                refclk = 1'b0;
  logic                rst_n  = 1'b1;
  logic [CHANNELS-1:0] ce;
  logic [CHANNELS-1:0] outclk;
  logic [CHANNELS-1:0] ch_locked;
  logic                locked;

  ce_synth_if #(.CH_W(CH_W), .ACC_W(ACC_W)) cfg_bus ();

  ce_synth #(
    .CHANNELS(CHANNELS),
    .ACC_W   (ACC_W),
    .SETTLE  (SETTLE),
    .INIT_INC(24'h00_10_80)
  ) dut (
    .refclk   (refclk),
    .rst_n    (rst_n),
    .cfg      (cfg_bus),
    .ce       (ce),
    .outclk   (outclk),
    .ch_locked(ch_locked),
    .locked   (locked)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    kind;
    int    ch;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   ce_cnt [CHANNELS];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Insert keeping the queue ordered by cycle (stable for equal cycles).
  function automatic void expect_at(int c, int k, int ch, int v, string n);
    exp_t e;
    int   idx;
    e   = '{cyc: c, kind: k, ch: ch, val: v, name: n};
    idx = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endfunction

  task automatic wait_neg(input int n);
    while (cyc < n) @(negedge refclk);
  endtask

  // Drive the config bus so it is sampled on edge k.
  task automatic drive(input int k, input bit we, input int ch, input int inc, input bit ps);
    wait_neg(k - 1);
    cfg_bus.cfg_we     = we;
    cfg_bus.cfg_ch     = CH_W'(ch);
    cfg_bus.cfg_inc    = ACC_W'(inc);
    cfg_bus.phase_sync = ps;
    $display("[TB] edge %0d: we=%0b ch=%0d inc=0x%02h phase_sync=%0b", k, we, ch, inc, ps);
    @(negedge refclk);
    cfg_bus.cfg_we     = 1'b0;
    cfg_bus.phase_sync = 1'b0;
  endtask

  // Monitor / scoreboard checker.
  initial begin
    exp_t e;
    int   act;
    for (int i = 0; i < CHANNELS; i++) ce_cnt[i] = 0;
    forever begin
      @(negedge refclk);
      #1;
      for (int i = 0; i < CHANNELS; i++) if (ce[i]) ce_cnt[i]++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.kind == K_CLR) begin
          ce_cnt[e.ch] = 0;
        end else begin
          case (e.kind)
            K_CE:     act = int'(ce[e.ch]);
            K_OCLK:   act = int'(outclk[e.ch]);
            K_LCK:    act = int'(ch_locked[e.ch]);
            K_LOCKED: act = int'(locked);
            default:  act = ce_cnt[e.ch];
          endcase
          n_tests++;
          if (e.cyc != cyc || act != e.val) begin
            n_fail++;
            $display("[TB] FAIL %s ch%0d cyc %0d (sampled %0d): got %0d, expected %0d",
                     e.name, e.ch, e.cyc, cyc, act, e.val);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_bus.cfg_we     = 1'b0;
    cfg_bus.cfg_ch     = '0;
    cfg_bus.cfg_inc    = '0;
    cfg_bus.phase_sync = 1'b0;

    // ---------------- expectations ----------------
    // Reset held over cycles 1..2: everything low.
    for (int c = 1; c <= 2; c++) begin
      for (int i = 0; i < CHANNELS; i++) begin
        expect_at(c, K_CE,   i, 0, "rst_ce");
        expect_at(c, K_OCLK, i, 0, "rst_outclk");
        expect_at(c, K_LCK,  i, 0, "rst_ch_locked");
      end
      expect_at(c, K_LOCKED, 0, 0, "rst_locked");
    end
    // Released before edge 3: ch0 0x80 toggles, ch1 0x10 wraps at edge 18,
    // both lock 16 edges after release, ch2 idle so locked stays 0.
    expect_at(3,  K_OCLK,   0, 1, "init_outclk0");
    expect_at(3,  K_CE,     0, 0, "init_ce0");
    expect_at(4,  K_CE,     0, 1, "init_ce0_wrap");
    expect_at(4,  K_OCLK,   0, 0, "init_outclk0");
    expect_at(17, K_LCK,    0, 0, "init_lock0_early");
    expect_at(18, K_LCK,    0, 1, "init_lock0");
    expect_at(17, K_LCK,    1, 0, "init_lock1_early");
    expect_at(18, K_LCK,    1, 1, "init_lock1");
    expect_at(18, K_LCK,    2, 0, "init_lock2_idle");
    expect_at(18, K_LOCKED, 0, 0, "init_locked");
    expect_at(17, K_CE,     1, 0, "init_ce1");
    expect_at(18, K_CE,     1, 1, "init_ce1_wrap");

    // ch0 <= 0x40 at edge 21 (acc 0x80 after that edge): wraps 23,27,...
    expect_at(20, K_LCK, 0, 1, "t1_lock_before");
    expect_at(21, K_LCK, 0, 0, "t1_lock_drop");
    expect_at(36, K_LCK, 0, 0, "t1_lock_settling");
    expect_at(37, K_LCK, 0, 1, "t1_lock_rise");
    for (int c = 21; c <= 34; c++)
      expect_at(c, K_CE, 0, (c >= 23 && (c - 23) % 4 == 0) ? 1 : 0, "t1_ce0");
    for (int c = 25; c <= 32; c++)
      expect_at(c, K_OCLK, 0, ((c - 25) % 4 < 2) ? 1 : 0, "t1_outclk0");
    expect_at(24, K_CLR, 0, 0, "t1_clr");
    expect_at(40, K_CNT, 0, 4, "t1_ce0_count");

    // ch1 <= 0x55 at edge 41; acc is 0x70 after edge 41, then 765 adds of
    // 0x55 over edges 42..806: 0x70 + 65025 = 65137 -> 254 wraps.
    expect_at(41,  K_CLR,    1, 0,   "t2_clr");
    expect_at(41,  K_LCK,    1, 0,   "t2_lock_drop");
    expect_at(56,  K_LCK,    1, 0,   "t2_lock_settling");
    expect_at(57,  K_LCK,    1, 1,   "t2_lock_rise");
    expect_at(57,  K_LOCKED, 0, 0,   "t2_locked_ch2_idle");
    expect_at(806, K_CNT,    1, 254, "t2_ce1_count");

    // ch2 <= 0x33 at 810 (locks at 826, all channels locked), then 0 at 830.
    expect_at(825, K_LCK,    2, 0, "t3_lock2_early");
    expect_at(825, K_LOCKED, 0, 0, "t3_locked_early");
    expect_at(826, K_LCK,    2, 1, "t3_lock2");
    expect_at(826, K_LOCKED, 0, 1, "t3_locked");
    expect_at(829, K_LCK,    2, 1, "t3_lock2_hold");
    expect_at(829, K_LOCKED, 0, 1, "t3_locked_hold");
    expect_at(830, K_LCK,    2, 0, "t3_lock2_drop");
    expect_at(830, K_LOCKED, 0, 0, "t3_locked_drop");
    expect_at(830, K_CLR,    2, 0, "t3_clr");
    expect_at(845, K_OCLK,   2, 1, "t3_outclk2_frozen");
    expect_at(845, K_LCK,    2, 0, "t3_lock2_low");
    expect_at(845, K_LOCKED, 0, 0, "t3_locked_low");
    expect_at(860, K_OCLK,   2, 1, "t3_outclk2_frozen");
    expect_at(860, K_CNT,    2, 0, "t3_ce2_count");
    // Write to channel 3 (out of range) at 862: nothing moves.
    expect_at(862, K_CLR,  2, 0, "t3b_clr");
    expect_at(862, K_LCK,  0, 1, "t3b_lock0");
    expect_at(862, K_LCK,  1, 1, "t3b_lock1");
    expect_at(862, K_LCK,  2, 0, "t3b_lock2");
    expect_at(863, K_CE,   0, 1, "t3b_ce0");
    expect_at(864, K_CE,   0, 0, "t3b_ce0");
    expect_at(870, K_OCLK, 2, 1, "t3b_outclk2");
    expect_at(878, K_LCK,  0, 1, "t3b_lock0_late");
    expect_at(878, K_LCK,  1, 1, "t3b_lock1_late");
    expect_at(880, K_CNT,  2, 0, "t3b_ce2_count");

    // ch0, ch1 both 0x20 but offset; phase_sync at 900 aligns them.
    expect_at(892, K_CE, 0, 1, "t4_ce0_pre");
    expect_at(896, K_CE, 0, 0, "t4_ce0_pre");
    expect_at(896, K_CE, 1, 1, "t4_ce1_pre");
    for (int c = 900; c <= 917; c++) begin
      expect_at(c, K_CE, 0, (c > 900 && (c - 900) % 8 == 0) ? 1 : 0, "t4_ce0_sync");
      expect_at(c, K_CE, 1, (c > 900 && (c - 900) % 8 == 0) ? 1 : 0, "t4_ce1_sync");
    end
    for (int c = 900; c <= 911; c++) begin
      expect_at(c, K_OCLK, 0, ((c - 900) % 8 >= 4) ? 1 : 0, "t4_outclk0_sync");
      expect_at(c, K_OCLK, 1, ((c - 900) % 8 >= 4) ? 1 : 0, "t4_outclk1_sync");
    end
    // phase_sync + write ch0 <= 0x40 at 920.
    expect_at(920, K_OCLK, 0, 0, "t4b_outclk0");
    expect_at(920, K_OCLK, 1, 0, "t4b_outclk1");
    expect_at(920, K_CE,   0, 0, "t4b_ce0");
    expect_at(920, K_LCK,  0, 0, "t4b_lock0_drop");
    for (int c = 921; c <= 928; c++) begin
      expect_at(c, K_CE, 0, (c == 924 || c == 928) ? 1 : 0, "t4b_ce0");
      expect_at(c, K_CE, 1, (c == 928) ? 1 : 0, "t4b_ce1");
    end

    // Rewrite ch0 at 928 (8 edges into settling): locks at 944, not 936.
    expect_at(936, K_LCK, 0, 0, "t5_lock0_restart");
    expect_at(943, K_LCK, 0, 0, "t5_lock0_restart");
    expect_at(944, K_LCK, 0, 1, "t5_lock0_rise");

    // ch1 <= 0x30 at 950, reset asserted between edge 956 and the next
    // falling edge, held through 958.
    expect_at(955, K_LCK,  0, 1, "t6_lock0_before");
    expect_at(955, K_OCLK, 1, 1, "t6_outclk1_before");
    for (int c = 956; c <= 958; c++) begin
      for (int i = 0; i < CHANNELS; i++) begin
        expect_at(c, K_CE,   i, 0, "t6_rst_ce");
        expect_at(c, K_OCLK, i, 0, "t6_rst_outclk");
        expect_at(c, K_LCK,  i, 0, "t6_rst_ch_locked");
      end
      expect_at(c, K_LOCKED, 0, 0, "t6_rst_locked");
    end
    expect_at(959, K_OCLK,   0, 1, "t6_outclk0");
    expect_at(959, K_CE,     0, 0, "t6_ce0");
    expect_at(960, K_CE,     0, 1, "t6_ce0_wrap");
    expect_at(973, K_LCK,    0, 0, "t6_lock0_early");
    expect_at(974, K_LCK,    0, 1, "t6_lock0");
    expect_at(973, K_LCK,    1, 0, "t6_lock1_early");
    expect_at(974, K_LCK,    1, 1, "t6_lock1");
    expect_at(974, K_LCK,    2, 0, "t6_lock2_idle");
    expect_at(974, K_LOCKED, 0, 0, "t6_locked");
    expect_at(990, K_LOCKED, 0, 0, "t6_locked_late");
    expect_at(973, K_CE,     1, 0, "t6_ce1");
    expect_at(974, K_CE,     1, 1, "t6_ce1_wrap");

    // ---------------- stimulus ----------------
    #2 rst_n = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    $display("[TB] reset released before edge 3");

    drive(21,  1'b1, 0, 'h40, 1'b0);
    drive(41,  1'b1, 1, 'h55, 1'b0);
    drive(810, 1'b1, 2, 'h33, 1'b0);
    drive(830, 1'b1, 2, 'h00, 1'b0);
    drive(862, 1'b1, 3, 'h77, 1'b0);
    drive(890, 1'b1, 0, 'h20, 1'b0);
    drive(895, 1'b1, 1, 'h20, 1'b0);
    drive(900, 1'b0, 0, 'h00, 1'b1);
    drive(920, 1'b1, 0, 'h40, 1'b1);
    drive(928, 1'b1, 0, 'h40, 1'b0);
    drive(950, 1'b1, 1, 'h30, 1'b0);

    wait_neg(955);
    @(posedge refclk);
    #2 rst_n = 1'b0;
    $display("[TB] reset asserted mid-cycle after edge 956");
    wait_neg(958);
    rst_n = 1'b1;
    $display("[TB] reset released before edge 959");

    wait_neg(1000);
    #3;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.kind != K_CLR) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL %s ch%0d cyc %0d: never checked, expected %0d", e.name, e.ch, e.cyc, e.val);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
